// File: rtl/updown_bounce_counter.sv
// Up/down counter between programmable bounds lo..hi by step: bounce, up-wrap, down-wrap and hold modes.
// Latency: cnt, dir, turn and wrap update one cycle after the inputs; at_lo, at_hi and cfg_err are combinational.
// Backpressure: none; en=0, mode=11 or a bad config freezes the counter, and load always wins over counting.
module updown_bounce_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [STEP_W-1:0] step,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  output logic [WIDTH-1:0]  cnt,
  output logic              dir,
  output logic              at_lo,
  output logic              at_hi,
  output logic              turn,
  output logic              wrap,
  output logic              cfg_err
);

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_UP     = 2'b01;
  localparam logic [1:0] MODE_DOWN   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  // One extra bit on every sum/difference so that, e.g., 250+15 compares as 265 rather than 9.
  logic [WIDTH:0]   step_x;
  logic [WIDTH:0]   cnt_x;
  logic [WIDTH:0]   lo_x;
  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   lo_plus;
  logic [WIDTH:0]   dn_diff;
  logic             out_of_range;
  logic             upd;

  logic [WIDTH-1:0] cnt_n;
  logic             dir_n;
  logic             turn_n;
  logic             wrap_n;

  assign step_x  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign cnt_x   = {1'b0, cnt};
  assign lo_x    = {1'b0, lo};
  assign hi_x    = {1'b0, hi};
  assign up_sum  = cnt_x + step_x;
  assign lo_plus = lo_x + step_x;
  assign dn_diff = cnt_x - step_x;

  assign at_lo        = (cnt == lo);
  assign at_hi        = (cnt == hi);
  assign cfg_err      = (lo > hi) || (step == '0);
  assign out_of_range = (cnt < lo) || (cnt > hi);
  assign upd          = en && (mode != MODE_HOLD) && !cfg_err;

  // Next-state selection: load, then out-of-range recovery, then the per-mode stepping rule.
  always_comb begin
    cnt_n  = cnt;
    dir_n  = dir;
    turn_n = 1'b0;
    wrap_n = 1'b0;
    if (load) begin
      cnt_n = load_val;
      dir_n = 1'b1;
    end else if (upd) begin
      if (out_of_range) begin
        cnt_n = lo;
        dir_n = 1'b1;
      end else begin
        case (mode)
          MODE_BOUNCE: begin
            // A degenerate range parks at lo without toggling dir or pulsing turn.
            if (lo != hi) begin
              if (dir) begin
                if (up_sum >= hi_x) begin
                  cnt_n  = hi;
                  dir_n  = 1'b0;
                  turn_n = 1'b1;
                end else begin
                  cnt_n = up_sum[WIDTH-1:0];
                end
              end else begin
                if (cnt_x <= lo_plus) begin
                  cnt_n  = lo;
                  dir_n  = 1'b1;
                  turn_n = 1'b1;
                end else begin
                  cnt_n = dn_diff[WIDTH-1:0];
                end
              end
            end
          end
          MODE_UP: begin
            dir_n = 1'b1;
            if (up_sum > hi_x) begin
              cnt_n  = lo;
              wrap_n = 1'b1;
            end else begin
              cnt_n = up_sum[WIDTH-1:0];
            end
          end
          MODE_DOWN: begin
            dir_n = 1'b0;
            if (cnt_x < lo_plus) begin
              cnt_n  = hi;
              wrap_n = 1'b1;
            end else begin
              cnt_n = dn_diff[WIDTH-1:0];
            end
          end
          default: begin
            cnt_n = cnt;
          end
        endcase
      end
    end
  end

  // State register with synchronous reset taking priority over load and counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dir  <= 1'b1;
      turn <= 1'b0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_n;
      dir  <= dir_n;
      turn <= turn_n;
      wrap <= wrap_n;
    end
  end

endmodule

// File: doc/updown_bounce_counter.md
Name: updown_bounce_counter

Overview:
Parametrised up/down counter: successor to the fixed 0..4 bounce counter.
- Counts between runtime-programmable bounds `lo`..`hi` by a programmable `step`.
- Supports three counting modes (bounce, up-wrap, down-wrap) plus hold, a synchronous load, and an enable.
- Publishes direction, bound flags and turn/wrap event pulses for downstream sequencers, PWM/triangle generators and address walkers.

Parameters:
- WIDTH, 8, width of count, bounds and load value.
- STEP_W, 4, width of the step input.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  count enable; when 0, cnt and dir hold.
- mode  in  2  00 bounce, 01 up-wrap, 10 down-wrap, 11 hold.
- lo  in  WIDTH  lower bound (unsigned, sampled every cycle).
- hi  in  WIDTH  upper bound (unsigned, sampled every cycle).
- step  in  STEP_W  increment magnitude (unsigned).
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value written on load.
- cnt  out  WIDTH  registered count.
- dir  out  1  registered direction: 1 up, 0 down.
- at_lo  out  1  combinational: cnt == lo.
- at_hi  out  1  combinational: cnt == hi.
- turn  out  1  registered 1-cycle pulse: bounce direction reversed this update.
- wrap  out  1  registered 1-cycle pulse: wrap mode wrapped this update.
- cfg_err  out  1  combinational: (lo > hi) or (step == 0).

Behaviour:
- Reset (sync, highest priority): cnt=0, dir=1, turn=0, wrap=0.
- Priority: rst > load > (en and valid config) > hold.
- turn and wrap default to 0 every cycle; they are 1 only for the cycle following the qualifying update.
- Load: cnt <= load_val (no clamping), dir <= 1. Load takes effect regardless of en, mode and cfg_err.
- Hold: cnt and dir hold when any of these is true:
  - en=0
  - mode=11
  - cfg_err=1
- Arithmetic: all next-value sums and differences use WIDTH+1 bits, so no silent modulo-2^WIDTH wrap occurs; step is zero-extended.
- Out-of-range: on an enabled update with cnt < lo or cnt > hi:
  - cnt <= lo, dir <= 1, no pulse.
  - This applies in every counting mode and overrides the mode rules below.
- Bounce (mode 00), in range:
  - dir=1:
    - if cnt+step >= hi: cnt <= hi, dir <= 0, turn <= 1.
    - else cnt <= cnt+step.
  - dir=0:
    - if cnt <= lo+step: cnt <= lo, dir <= 1, turn <= 1.
    - else cnt <= cnt-step.
  - The update that lands exactly on a bound also reverses direction, so each bound appears exactly once per sweep.
    - lo=0, hi=4, step=1 gives: 0 1 2 3 4 3 2 1 0 1 …
  - Overshoot clamps to the bound (no reflection of the remainder).
  - lo == hi: cnt stays at lo, dir unchanged, no turn.
- Up-wrap (mode 01), in range:
  - if cnt+step > hi: cnt <= lo, wrap <= 1.
  - else cnt <= cnt+step.
  - dir <= 1.
- Down-wrap (mode 10), in range:
  - if cnt < lo+step: cnt <= hi, wrap <= 1.
  - else cnt <= cnt-step.
  - dir <= 0.
- Mode change: takes effect on the next enabled update. Switching into bounce keeps the current dir.
- Bounds/step change mid-count: applies on the next update. If cnt is left outside the new range, the out-of-range rule applies.
- Reset mid-sweep: cnt=0 and dir=1 in the next cycle regardless of en or load.
- cfg_err with load=1: the load still occurs.

Test Plan:
1. Bounce sweep:
   - Stimulus: rst 2 cycles, then lo=0, hi=4, step=1, mode=00, en=1 for 20 cycles.
   - Response: cnt = 0 1 2 3 4 3 2 1 0 1 2 3 4 3 2 1 0 1 2 3.
   - turn high in the cycles cnt shows 4 and 0 (after the first 0); dir flips alongside.
2. Overshoot clamp:
   - Stimulus: lo=2, hi=11, step=4, bounce from reset, load_val=2.
   - Response: cnt = 2 6 10 11 7 3 2 6.
   - turn pulses with 11 and with 2; at_hi=1 only when cnt=11.
3. Wrap modes:
   - Stimulus: mode=01, lo=3, hi=9, step=3, load 3.
   - Response: cnt = 3 6 9 3 6, wrap pulses with the second 3.
   - Then mode=10 from cnt=6: cnt = 3 9 6 3 9, wrap pulses with each 9; dir=0.
4. Enable/hold/cfg_err:
   - Stimulus: en=0 for 3 cycles mid-sweep -> cnt and dir frozen.
   - Stimulus: mode=11 -> frozen.
   - Stimulus: lo=9, hi=5 -> cfg_err=1, frozen.
   - Stimulus: load with load_val=7 while cfg_err=1 -> cnt=7, dir=1.
5. Out-of-range and bound change:
   - Stimulus: bounce at cnt=200 going up, WIDTH=8, hi changes from 250 to 100.
   - Response: next cnt=lo, dir=1, no pulse.
   - Stimulus: with hi=255, step=15 from cnt=250.
   - Response: cnt=255, turn=1, no 8-bit overflow.
6. Reset/priority:
   - Stimulus: rst and load asserted together mid-sweep.
   - Response: cnt=0, dir=1, turn=0, wrap=0 the next cycle; counting resumes from 0 when rst deasserts.
